warp_lsu: RTL and testbench
===========================

Name: warp_lsu

Overview:
- Warp-level load/store unit. Produces the per-thread `lsu_out` values that the register file writes back in WARP_UPDATE.
- Consumes the `rs1`/`rs2` operands the register file reads out in WARP_REQUEST.
- Serializes the active threads' accesses onto one valid/ready data-memory read port and one write port.
- One instance per warp, between the register file and the data-memory arbiter.

Parameters:
- THREADS_PER_WARP, 32, threads per warp (lanes).
- DATA_WIDTH, `DATA_WIDTH, data word width.
- ADDR_WIDTH, 8, data-memory address width.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  warp enable; when low the FSM holds its state
- thread_enable  input  THREADS_PER_WARP  execution mask
- warp_state  input  warp_state_t  current warp pipeline state
- decoded_mem_read_enable  input  1  instruction is a load
- decoded_mem_write_enable  input  1  instruction is a store
- decoded_immediate  input  DATA_WIDTH  address offset
- rs1  input  DATA_WIDTH x THREADS_PER_WARP  per-thread base address
- rs2  input  DATA_WIDTH x THREADS_PER_WARP  per-thread store data
- mem_read_valid  output  1  read request
- mem_read_address  output  ADDR_WIDTH  read address
- mem_read_ready  input  1  request accepted; read data valid this cycle
- mem_read_data  input  DATA_WIDTH  read data
- mem_write_valid  output  1  write request
- mem_write_address  output  ADDR_WIDTH  write address
- mem_write_data  output  DATA_WIDTH  write data
- mem_write_ready  input  1  write accepted
- lsu_out  output  DATA_WIDTH x THREADS_PER_WARP  per-thread load result
- lsu_state  output  lsu_state_t  IDLE / REQUESTING / DONE

Behaviour:
- Reset, sampled at posedge clk:
  - lsu_state=IDLE; pending mask=0.
  - All mem_* outputs=0, including valids.
  - lsu_out[*]=0.
  - Applies mid-transaction too: the request is abandoned and valid drops after that edge; memory must tolerate this.
- All state changes only when `enable` is high; with enable low, registers and outputs hold.
- IDLE -> REQUESTING, at the edge where all of these hold: warp_state==WARP_WAIT, (read|write) enable set, thread_enable!=0. At that edge:
  - latch pending=thread_enable and op=read/write; read has priority if both are set.
  - latch per-thread addr[i]=(rs1[i]+decoded_immediate)[ADDR_WIDTH-1:0]; the sum is truncated and wraps modulo 2^ADDR_WIDTH.
  - latch wdata[i]=rs2[i].
- IDLE -> DONE directly when warp_state==WARP_WAIT with a memory op and thread_enable==0. No memory traffic.
- Non-memory instructions: IDLE is held, all valids stay 0.
- REQUESTING:
  - sel = lowest-index set bit of pending.
  - The valid for the latched op is high, with address/data = addr[sel]/wdata[sel]. Valid, address and data stay stable until ready.
  - On an edge with ready high:
    - pending[sel] is cleared.
    - For a load, lsu_out[sel]<=mem_read_data.
    - If other bits remain pending, the next thread is presented the following cycle, so back-to-back transfers are possible.
    - Otherwise the FSM moves to DONE and valid deasserts.
  - N active threads with ready tied high take exactly N cycles in REQUESTING.
- DONE:
  - Valids are 0.
  - The FSM stays in DONE until warp_state==WARP_UPDATE, then -> IDLE at that edge.
  - lsu_out is stable throughout DONE and WARP_UPDATE.
- Inactive threads: lsu_out[i] retains its previous value. Stores never write lsu_out.
- thread_enable, rs1 and rs2 changes after launch have no effect.
- The FSM never enters WARP_UPDATE early. The warp scheduler holds WARP_WAIT while lsu_state!=DONE for memory instructions.

Decomposition:
- Shared package (alongside warp_state_t and data_t):
  - lsu_state_t enum {LSU_IDLE, LSU_REQUESTING, LSU_DONE}
  - ADDR_WIDTH default constant
- Sub-module `lane_priority_sel`:
  - combinational lowest-set-bit encoder over THREADS_PER_WARP
  - outputs index plus an any-set flag
  - reusable by the scheduler/arbiter

Test Plan:
- Load, 4 lanes [0,1,2,3] active, rs1[i]=0x10+i, imm=4, ready tied high -> read addresses 0x14,0x15,0x16,0x17 on consecutive cycles; lsu_out[i]=mem[addr]; DONE after 4 cycles; IDLE after the WARP_UPDATE edge.
- Store, mask 0b1010, rs1=0x20, rs2[i]=100+i, mem_write_ready low for 3 cycles on the first request -> lane1 address 0x20/data 101 held stable 3 cycles; then lane3 address 0x20/data 103; lsu_out unchanged.
- Address wrap: ADDR_WIDTH=8, rs1=0xFE, imm=5 -> mem_read_address=0x03.
- Empty mask with a load in WARP_WAIT -> DONE next cycle; mem_read_valid never asserts.
- Reset asserted while REQUESTING at lane 2 of 4 -> valid=0, lsu_state=IDLE, lsu_out all 0 on the next cycle.
- enable low for 2 cycles mid-REQUESTING with ready high -> no handshake consumed, state frozen; the sequence resumes at the same lane when enable returns.

Source files
------------

// File: rtl/warp_lsu_pkg.sv
// Shared types for the warp pipeline: warp/LSU state enums, data word type and default widths.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package warp_lsu_pkg;

    localparam int LSU_DATA_WIDTH = `DATA_WIDTH;
    localparam int LSU_ADDR_WIDTH = 8;

    typedef logic [LSU_DATA_WIDTH-1:0] data_t;

    typedef enum logic [2:0] {
        WARP_IDLE,
        WARP_FETCH,
        WARP_DECODE,
        WARP_REQUEST,
        WARP_WAIT,
        WARP_EXECUTE,
        WARP_UPDATE,
        WARP_DONE
    } warp_state_t;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQUESTING,
        LSU_DONE
    } lsu_state_t;

endpackage

// File: rtl/lane_priority_sel.sv
// Lowest-set-bit encoder over a lane mask; idx is only meaningful when any is high.
module lane_priority_sel #(
    parameter int LANES = 32,
    parameter int IDX_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic [LANES-1:0] mask,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        any = |mask;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/warp_lsu.sv
// Warp load/store unit: latches per-lane addresses/data at launch, then serializes
// active lanes lowest-first onto one read or write valid/ready port.
module warp_lsu
    import warp_lsu_pkg::*;
#(
    parameter int THREADS_PER_WARP = 32,
    parameter int DATA_WIDTH       = LSU_DATA_WIDTH,
    parameter int ADDR_WIDTH       = LSU_ADDR_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [THREADS_PER_WARP-1:0] thread_enable,
    input  warp_state_t                 warp_state,
    input  logic                        decoded_mem_read_enable,
    input  logic                        decoded_mem_write_enable,
    input  logic [DATA_WIDTH-1:0]       decoded_immediate,
    input  logic [DATA_WIDTH-1:0]       rs1 [THREADS_PER_WARP],
    input  logic [DATA_WIDTH-1:0]       rs2 [THREADS_PER_WARP],
    output logic                        mem_read_valid,
    output logic [ADDR_WIDTH-1:0]       mem_read_address,
    input  logic                        mem_read_ready,
    input  logic [DATA_WIDTH-1:0]       mem_read_data,
    output logic                        mem_write_valid,
    output logic [ADDR_WIDTH-1:0]       mem_write_address,
    output logic [DATA_WIDTH-1:0]       mem_write_data,
    input  logic                        mem_write_ready,
    output logic [DATA_WIDTH-1:0]       lsu_out [THREADS_PER_WARP],
    output lsu_state_t                  lsu_state
);

    localparam int IDX_W = (THREADS_PER_WARP > 1) ? $clog2(THREADS_PER_WARP) : 1;
    localparam logic [THREADS_PER_WARP-1:0] LANE_ONE = 1;

    logic [THREADS_PER_WARP-1:0] pending;
    logic [THREADS_PER_WARP-1:0] pending_next;
    logic                        op_read;
    logic [ADDR_WIDTH-1:0]       addr  [THREADS_PER_WARP];
    logic [DATA_WIDTH-1:0]       wdata [THREADS_PER_WARP];
    logic [IDX_W-1:0]            sel;
    logic                        any_pending;
    logic                        active;
    logic                        is_mem;
    logic                        xfer;

    lane_priority_sel #(
        .LANES (THREADS_PER_WARP),
        .IDX_W (IDX_W)
    ) u_sel (
        .mask (pending),
        .idx  (sel),
        .any  (any_pending)
    );

    // Port outputs derive only from registered state, so they hold while enable is low
    // and stay stable until the handshake completes.
    assign active            = (lsu_state == LSU_REQUESTING) && any_pending;
    assign mem_read_valid    = active && op_read;
    assign mem_write_valid   = active && !op_read;
    assign mem_read_address  = mem_read_valid  ? addr[sel]  : '0;
    assign mem_write_address = mem_write_valid ? addr[sel]  : '0;
    assign mem_write_data    = mem_write_valid ? wdata[sel] : '0;

    assign is_mem       = decoded_mem_read_enable | decoded_mem_write_enable;
    assign xfer         = (mem_read_valid & mem_read_ready) | (mem_write_valid & mem_write_ready);
    assign pending_next = pending & ~(LANE_ONE << sel);

    always_ff @(posedge clk) begin
        if (reset) begin
            lsu_state <= LSU_IDLE;
            pending   <= '0;
            op_read   <= 1'b0;
            for (int i = 0; i < THREADS_PER_WARP; i++) begin
                lsu_out[i] <= '0;
                addr[i]    <= '0;
                wdata[i]   <= '0;
            end
        end else if (enable) begin
            case (lsu_state)
                LSU_IDLE: begin
                    if (warp_state == WARP_WAIT && is_mem) begin
                        if (thread_enable != '0) begin
                            lsu_state <= LSU_REQUESTING;
                            pending   <= thread_enable;
                            op_read   <= decoded_mem_read_enable;
                            for (int i = 0; i < THREADS_PER_WARP; i++) begin
                                addr[i]  <= ADDR_WIDTH'(rs1[i] + decoded_immediate);
                                wdata[i] <= rs2[i];
                            end
                        end else begin
                            lsu_state <= LSU_DONE;
                        end
                    end
                end
                LSU_REQUESTING: begin
                    if (xfer) begin
                        pending <= pending_next;
                        if (op_read) begin
                            lsu_out[sel] <= mem_read_data;
                        end
                        if (pending_next == '0) begin
                            lsu_state <= LSU_DONE;
                        end
                    end
                end
                LSU_DONE: begin
                    if (warp_state == WARP_UPDATE) begin
                        lsu_state <= LSU_IDLE;
                    end
                end
                default: lsu_state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_warp_lsu.sv
// Directed bench for warp_lsu: load, stalled store, address wrap, empty mask, enable freeze, mid-flight reset.
module tb_warp_lsu;
    import warp_lsu_pkg::*;

    localparam int T  = 32;
    localparam int DW = LSU_DATA_WIDTH;
    localparam int AW = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [T-1:0]      thread_enable;
    warp_state_t       warp_state;
    logic              decoded_mem_read_enable;
    logic              decoded_mem_write_enable;
    logic [DW-1:0]     decoded_immediate;
    logic [DW-1:0]     rs1 [T];
    logic [DW-1:0]     rs2 [T];
    logic              mem_read_valid;
    logic [AW-1:0]     mem_read_address;
    logic              mem_read_ready;
    logic [DW-1:0]     mem_read_data;
    logic              mem_write_valid;
    logic [AW-1:0]     mem_write_address;
    logic [DW-1:0]     mem_write_data;
    logic              mem_write_ready;
    logic [DW-1:0]     lsu_out [T];
    lsu_state_t        lsu_state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Memory content: word at address a reads as 0x1000 + a.
    assign mem_read_data = 16'h1000 + {8'h00, mem_read_address};

    warp_lsu #(
        .THREADS_PER_WARP (T),
        .DATA_WIDTH       (DW),
        .ADDR_WIDTH       (AW)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .enable                   (enable),
        .thread_enable            (thread_enable),
        .warp_state               (warp_state),
        .decoded_mem_read_enable  (decoded_mem_read_enable),
        .decoded_mem_write_enable (decoded_mem_write_enable),
        .decoded_immediate        (decoded_immediate),
        .rs1                      (rs1),
        .rs2                      (rs2),
        .mem_read_valid           (mem_read_valid),
        .mem_read_address         (mem_read_address),
        .mem_read_ready           (mem_read_ready),
        .mem_read_data            (mem_read_data),
        .mem_write_valid          (mem_write_valid),
        .mem_write_address        (mem_write_address),
        .mem_write_data           (mem_write_data),
        .mem_write_ready          (mem_write_ready),
        .lsu_out                  (lsu_out),
        .lsu_state                (lsu_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b1;
        thread_enable = '0;
        warp_state = WARP_IDLE;
        decoded_mem_read_enable = 1'b0;
        decoded_mem_write_enable = 1'b0;
        decoded_immediate = '0;
        mem_read_ready = 1'b0;
        mem_write_ready = 1'b0;
        for (int i = 0; i < T; i++) begin
            rs1[i] = '0;
            rs2[i] = '0;
        end
        step();
        step();
        reset = 1'b0;
        check("rst_state", 32'(lsu_state), 32'(LSU_IDLE));
        check("rst_rvalid", 32'(mem_read_valid), 0);
        check("rst_wvalid", 32'(mem_write_valid), 0);
        check("rst_out0", 32'(lsu_out[0]), 0);

        // Non-memory instruction in WAIT: stays idle.
        warp_state = WARP_WAIT;
        thread_enable = 32'hF;
        step();
        check("nonmem_idle", 32'(lsu_state), 32'(LSU_IDLE));

        // Load, lanes 0..3, base 0x10+i, imm 4, ready tied high.
        for (int i = 0; i < 4; i++) rs1[i] = DW'(16'h10 + i);
        decoded_immediate = 16'd4;
        decoded_mem_read_enable = 1'b1;
        mem_read_ready = 1'b1;
        step();
        check("ld_state_req", 32'(lsu_state), 32'(LSU_REQUESTING));
        check("ld_valid", 32'(mem_read_valid), 1);
        check("ld_addr0", 32'(mem_read_address), 32'h14);
        rs1[1] = 16'h0099;
        thread_enable = '0;
        step();
        check("ld_addr1", 32'(mem_read_address), 32'h15);
        step();
        check("ld_addr2", 32'(mem_read_address), 32'h16);
        step();
        check("ld_addr3", 32'(mem_read_address), 32'h17);
        check("ld_wvalid", 32'(mem_write_valid), 0);
        step();
        check("ld_done", 32'(lsu_state), 32'(LSU_DONE));
        check("ld_valid_off", 32'(mem_read_valid), 0);
        check("ld_out0", 32'(lsu_out[0]), 32'h1014);
        check("ld_out1", 32'(lsu_out[1]), 32'h1015);
        check("ld_out2", 32'(lsu_out[2]), 32'h1016);
        check("ld_out3", 32'(lsu_out[3]), 32'h1017);
        check("ld_out4", 32'(lsu_out[4]), 0);
        step();
        check("ld_hold_done", 32'(lsu_state), 32'(LSU_DONE));
        warp_state = WARP_UPDATE;
        step();
        check("ld_idle", 32'(lsu_state), 32'(LSU_IDLE));
        warp_state = WARP_EXECUTE;
        decoded_mem_read_enable = 1'b0;
        mem_read_ready = 1'b0;
        step();

        // Store, mask 1010, write port stalled for 3 cycles on lane 1.
        for (int i = 0; i < 4; i++) begin
            rs1[i] = 16'h0020;
            rs2[i] = DW'(100 + i);
        end
        decoded_immediate = '0;
        thread_enable = 32'b1010;
        decoded_mem_write_enable = 1'b1;
        warp_state = WARP_WAIT;
        step();
        for (int c = 0; c < 3; c++) begin
            check("st_stall_valid", 32'(mem_write_valid), 1);
            check("st_stall_addr", 32'(mem_write_address), 32'h20);
            check("st_stall_data", 32'(mem_write_data), 101);
            if (c < 2) step();
        end
        check("st_rvalid", 32'(mem_read_valid), 0);
        mem_write_ready = 1'b1;
        step();
        check("st_lane3_valid", 32'(mem_write_valid), 1);
        check("st_lane3_addr", 32'(mem_write_address), 32'h20);
        check("st_lane3_data", 32'(mem_write_data), 103);
        step();
        check("st_done", 32'(lsu_state), 32'(LSU_DONE));
        check("st_out1_kept", 32'(lsu_out[1]), 32'h1015);
        check("st_out3_kept", 32'(lsu_out[3]), 32'h1017);
        warp_state = WARP_UPDATE;
        mem_write_ready = 1'b0;
        decoded_mem_write_enable = 1'b0;
        step();
        check("st_idle", 32'(lsu_state), 32'(LSU_IDLE));

        // Address wrap: 0xFE + 5 -> 0x03.
        rs1[0] = 16'h00FE;
        decoded_immediate = 16'd5;
        thread_enable = 32'b1;
        decoded_mem_read_enable = 1'b1;
        warp_state = WARP_WAIT;
        step();
        check("wrap_addr", 32'(mem_read_address), 32'h03);
        mem_read_ready = 1'b1;
        step();
        check("wrap_done", 32'(lsu_state), 32'(LSU_DONE));
        check("wrap_out0", 32'(lsu_out[0]), 32'h1003);
        warp_state = WARP_UPDATE;
        step();

        // Empty mask load: straight to DONE with no traffic.
        thread_enable = '0;
        warp_state = WARP_WAIT;
        step();
        check("empty_done", 32'(lsu_state), 32'(LSU_DONE));
        check("empty_rvalid", 32'(mem_read_valid), 0);
        warp_state = WARP_UPDATE;
        step();
        check("empty_idle", 32'(lsu_state), 32'(LSU_IDLE));

        // Enable freeze mid-request, then reset while at lane 2 of 4.
        for (int i = 0; i < 4; i++) rs1[i] = DW'(16'h30 + i);
        decoded_immediate = '0;
        thread_enable = 32'hF;
        warp_state = WARP_WAIT;
        step();
        check("en_addr0", 32'(mem_read_address), 32'h30);
        step();
        check("en_addr1", 32'(mem_read_address), 32'h31);
        enable = 1'b0;
        step();
        step();
        check("en_frozen_state", 32'(lsu_state), 32'(LSU_REQUESTING));
        check("en_frozen_addr", 32'(mem_read_address), 32'h31);
        check("en_frozen_out1", 32'(lsu_out[1]), 32'h1015);
        enable = 1'b1;
        step();
        check("en_resume_addr", 32'(mem_read_address), 32'h32);
        check("en_resume_out1", 32'(lsu_out[1]), 32'h1031);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_state", 32'(lsu_state), 32'(LSU_IDLE));
        check("mid_rst_valid", 32'(mem_read_valid), 0);
        check("mid_rst_addr", 32'(mem_read_address), 0);
        check("mid_rst_out0", 32'(lsu_out[0]), 0);
        check("mid_rst_out1", 32'(lsu_out[1]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
